// File: rtl/mux_pkg.sv
// Shared constants and types for the 8:1 single-bit selector.
// Gate delays in the mux tree are enabled by defining MUX8BY1_GATE_DELAY_EN.
`timescale 1ns/10ps
package mux_pkg;

  localparam int unsigned MUX8_SEL_W = 3;
  localparam int unsigned MUX8_N_IN  = 8;

  // Per-gate propagation delay in ns, used only when MUX8BY1_GATE_DELAY_EN is defined.
  localparam real GATE_DELAY = 0.05;

  typedef logic [MUX8_SEL_W-1:0] sel3_t;

endpackage

// File: rtl/mux2by1.sv
// 2:1 single-bit mux built from NOT/AND/OR primitives: out = (a & ~s) | (b & s).
// With MUX8BY1_GATE_DELAY_EN defined, each primitive carries GATE_DELAY.
`timescale 1ns/10ps
module mux2by1
  import mux_pkg::*;
(
  output logic out,
  input  logic a,
  input  logic b,
  input  logic s
);

  logic s_n;
  logic a_g;
  logic b_g;

`ifdef MUX8BY1_GATE_DELAY_EN
  not #(GATE_DELAY) u_not  (s_n, s);
  and #(GATE_DELAY) u_and_a (a_g, a, s_n);
  and #(GATE_DELAY) u_and_b (b_g, b, s);
  or  #(GATE_DELAY) u_or   (out, a_g, b_g);
`else
  not u_not  (s_n, s);
  and u_and_a (a_g, a, s_n);
  and u_and_b (b_g, b, s);
  or  u_or   (out, a_g, b_g);
`endif

endmodule

// File: rtl/mux_8by1.sv
// Single-bit 8:1 selector: combinational out = ins[sel] through a three-level
// tree of mux2by1 gates, plus a registered copy out_q (sync active-high reset).
// Gate delays in the tree are enabled by defining MUX8BY1_GATE_DELAY_EN.
`timescale 1ns/10ps
module mux_8by1
  import mux_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MUX8_N_IN-1:0]  ins,
  input  logic [MUX8_SEL_W-1:0] sel,
  output logic                  out,
  output logic                  out_q
);

  sel3_t      sel_w;
  logic [3:0] lvl1;
  logic [1:0] lvl2;
  logic       out_d;

  assign sel_w = sel;

  // Level 1: sel[0] picks the odd input of each adjacent pair.
  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    mux2by1 u_mux (
      .out (lvl1[i]),
      .a   (ins[2*i]),
      .b   (ins[2*i+1]),
      .s   (sel_w[0])
    );
  end

  // Level 2: sel[1] pairs the level-1 results.
  for (genvar j = 0; j < 2; j++) begin : g_lvl2
    mux2by1 u_mux (
      .out (lvl2[j]),
      .a   (lvl1[2*j]),
      .b   (lvl1[2*j+1]),
      .s   (sel_w[1])
    );
  end

  // Level 3: sel[2] produces the final combinational output.
  mux2by1 u_lvl3 (
    .out (out),
    .a   (lvl2[0]),
    .b   (lvl2[1]),
    .s   (sel_w[2])
  );

  // Next value of the registered copy is simply the tree output.
  always_comb begin
    out_d = out;
  end

  // Registered copy; reset clears it but never touches out.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mux_8by1.sv
// Self-checking bench for mux_8by1: directed walks, exhaustive sweep, reset and
// latency sequences, and randomized traffic against a behavioural model.
`timescale 1ns/10ps
module tb_mux_8by1;

  logic       clk;
  logic       reset;
  logic [7:0] ins;
  logic [2:0] sel;
  logic       out;
  logic       out_q;

  int unsigned n_checks;
  int unsigned n_errors;
  logic        chk_en;
  logic        exp_q;

  mux_8by1 dut (
    .clk   (clk),
    .reset (reset),
    .ins   (ins),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: shift the input word right by the select and keep the low bit.
  function automatic logic model_out(input logic [7:0] w, input logic [2:0] s);
    int unsigned v;
    v = (int'(w) >> int'(s)) % 2;
    return (v == 1) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (ins=%h sel=%0d reset=%b t=%0t)",
               name, act, exp, ins, sel, reset, $time);
    end
  endtask

  // Drive new inputs shortly after a rising edge.
  task automatic drive(input logic r, input logic [7:0] w, input logic [2:0] s);
    @(posedge clk);
    #2;
    reset = r;
    ins   = w;
    sel   = s;
  endtask

  // Registered-output model: reset wins, else capture the selected bit.
  always @(posedge clk) begin
    exp_q <= reset ? 1'b0 : model_out(ins, sel);
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_vs_model", out, model_out(ins, sel));
      check("out_q_vs_model", out_q, exp_q);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    ins      = 8'hFF;
    sel      = 3'd0;

    // Reset held for two edges with all inputs high.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_out_q_zero", out_q, 1'b0);
    check("reset_out_not_forced", out, 1'b1);

    // Release with sel=5, ins=8'h20.
    drive(1'b0, 8'h20, 3'd5);
    @(negedge clk);
    check("release_before_edge", out_q, 1'b0);
    check("release_out", out, 1'b1);
    @(negedge clk);
    check("release_after_edge", out_q, 1'b1);

    // Reset mid-stream for one edge.
    drive(1'b1, 8'h20, 3'd5);
    @(negedge clk);
    check("mid_reset_before_edge", out_q, 1'b1);
    @(negedge clk);
    check("mid_reset_cleared", out_q, 1'b0);
    check("mid_reset_out", out, 1'b1);
    drive(1'b0, 8'h20, 3'd5);
    @(negedge clk);
    check("mid_release_before_edge", out_q, 1'b0);
    @(negedge clk);
    check("mid_release_recaptured", out_q, 1'b1);

    // One-hot and zero-hot walks with literal expectations.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        drive(1'b0, 8'b1 << i, 3'(j));
        #1;
        check("one_hot", out, (i == j) ? 1'b1 : 1'b0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        drive(1'b0, ~(8'b1 << i), 3'(j));
        #1;
        check("zero_hot", out, (i == j) ? 1'b0 : 1'b1);
      end
    end

    // Exhaustive sweep; the compare process checks each step at the falling edge.
    for (int w = 0; w < 256; w++) begin
      for (int s = 0; s < 8; s++) begin
        drive(1'b0, 8'(w), 3'(s));
      end
    end

    // Latency: toggle ins[3] with sel=3, out_q trails out by one cycle.
    drive(1'b0, 8'h00, 3'd3);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, (k % 2 == 1) ? 8'h08 : 8'h00, 3'd3);
      @(negedge clk);
      check("latency_out", out, (k % 2 == 1) ? 1'b1 : 1'b0);
      check("latency_out_q", out_q, (k > 0 && (k - 1) % 2 == 1) ? 1'b1 : 1'b0);
    end

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
            8'($urandom_range(255)), 3'($urandom_range(7)));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
